fpu_inq_ctl: RTL and testbench
==============================

Name: fpu_inq_ctl

Overview:
- Control block for the FPU input datapath and its input-queue SRAM.
- Tracks PCX request beats: one beat for single-source ops, two beats for two-source ops.
- Decides, each cycle, among three sources for the head request: forward the incoming request, read the queue SRAM, or bypass the just-written entry. It drives the datapath's fwrd/bp selects and the SRAM write/read controls.
- Issues the head request to the add, mul or div pipe when that pipe is ready, and returns one PCX credit per dequeue.

Parameters:
- DEPTH, 16, input-queue entries (power of two, minimum 2).
- PTR_W, 4, log2(DEPTH).

Ports:
- rclk  in  1  global clock, single clock domain.
- grst_l  in  1  synchronous active-low reset, sampled on rclk rising edge.
- beat_vld  in  1  PCX beat captured in datapath stage 1, aligned with fp_op_in.
- beat_1src  in  1  fp_op_in[7] of that beat; 1 = single-source request.
- in_pipe_sel  in  2  target pipe of the incoming request: 0 add, 1 mul, 2 div; 3 is illegal.
- head_pipe_sel  in  2  target pipe decoded from inq_op of the queued head.
- pipe_rdy  in  3  per-pipe accept ready, bit0 add, bit1 mul, bit2 div.
- fp_data_rdy  out  1  enable for the first-operand (srcb) capture register.
- inq_fwrd, inq_fwrd_inv  out  1 each  forward select and its complement.
- inq_bp, inq_bp_inv  out  1 each  bypass select and its complement.
- inq_we  out  1  SRAM write enable.
- inq_wr_ptr  out  PTR_W  SRAM write address.
- inq_rd_ptr  out  PTR_W  SRAM read address (combinational read).
- iss_vld  out  3  one-hot issue strobe to the add/mul/div pipe.
- fpu_pcx_credit  out  1  one-cycle credit-return pulse.
- inq_cnt  out  PTR_W+1  queue occupancy.
- inq_empty  out  1  inq_cnt==0.
- inq_ovf  out  1  sticky protocol-error flag.

Behaviour:
- Reset (grst_l=0 at an edge): FSM goes to IDLE; pointers, inq_cnt, inq_ovf, last_wr_vld and every registered output go to 0.
  - inq_fwrd_inv and inq_bp_inv read 1; inq_empty reads 1.
  - Reset asserted mid-request drops any partial two-beat request; no write and no credit.
- Beat FSM:
  - IDLE: beat_vld & beat_1src completes a request (req_done=1). beat_vld & ~beat_1src gives fp_data_rdy=1 and moves to WAIT_B2.
  - WAIT_B2: beat_vld completes the request (req_done=1) and returns to IDLE; beat_1src is ignored in this state.
  - fp_data_rdy = IDLE & beat_vld & ~beat_1src (combinational).
- Forward path: fwd = req_done & inq_cnt==0 & pipe_rdy[in_pipe_sel].
  - inq_fwrd=1, iss_vld[in_pipe_sel]=1, fpu_pcx_credit=1.
  - No SRAM write. Forward latency is 0 cycles from req_done.
- Enqueue: req_done & ~fwd drives inq_we=1 at inq_wr_ptr; wr_ptr advances next cycle and wraps DEPTH-1 to 0.
  - Requests arriving while inq_cnt>0 always enqueue, so order is preserved.
- Dequeue: deq = inq_cnt>0 & pipe_rdy[head_pipe_sel].
  - Drives iss_vld[head_pipe_sel]=1 and fpu_pcx_credit=1; rd_ptr advances and wraps.
- inq_fwrd=0 whenever inq_cnt>0.
- Bypass: last_wr_vld and last_wr_ptr hold the previous cycle's write.
  - inq_bp = last_wr_vld & (last_wr_ptr==rd_ptr) & inq_cnt>0, because the SRAM does not write through.
  - Otherwise inq_bp=0 and data comes from the SRAM.
- Occupancy: enqueue and dequeue in the same cycle leave inq_cnt unchanged. A forward never changes inq_cnt.
- Full: req_done with inq_cnt==DEPTH and no dequeue in that cycle is a PCX credit violation.
  - The write is suppressed, pointers are unchanged, and inq_ovf latches 1 until reset.
- in_pipe_sel==3 or head_pipe_sel==3 never issues.
- iss_vld is one-hot or zero; at most one issue per cycle.

Decomposition:
- Shared package fpu_inq_pkg holds:
  - pipe encodings PIPE_ADD=0, PIPE_MUL=1, PIPE_DIV=2;
  - FSM state typedef {IDLE, WAIT_B2};
  - DEPTH default.
- Natural sub-module: fpu_inq_ptr, the pointer/occupancy counter with wrap, full and empty.

Test Plan:
- Empty queue, single-source add beat, pipe_rdy=3'b001 -> same cycle inq_fwrd=1, iss_vld=001, credit=1, inq_we=0, inq_cnt stays 0.
- Two-source mul, beats at t and t+1, pipe_rdy=0 -> fp_data_rdy=1 at t only; inq_we=1 at t+1, ptr 0; inq_cnt=1 at t+2.
  - At t+2, inq_bp=1.
  - pipe_rdy=010 at t+2 -> iss_vld=010 and credit.
- Fill 16 entries with pipes stalled, then a 17th request -> inq_ovf=1, no write, inq_cnt=16. Drain 16 -> 16 credits, rd_ptr wraps to 0, inq_empty=1.
- inq_cnt=3, enqueue and dequeue in the same cycle -> inq_cnt stays 3, both pointers advance; the incoming request is not forwarded even though its pipe is ready.
- grst_l=0 in WAIT_B2 -> after release, a single beat is a new request; no stale write or credit.
- head_pipe_sel=2 with pipe_rdy=3'b011 -> no issue until bit2 rises; then a single div strobe.

Source files
------------

// File: rtl/fpu_inq_pkg.sv
// Shared definitions for the FPU input-queue control slice.
//   - pipe encodings used by in_pipe_sel / head_pipe_sel
//   - beat FSM state type
//   - default queue depth
//   - helpers that map a pipe select onto the ready vector / issue strobe
package fpu_inq_pkg;

    localparam int DEPTH_DEF = 16;

    localparam logic [1:0] PIPE_ADD = 2'd0;
    localparam logic [1:0] PIPE_MUL = 2'd1;
    localparam logic [1:0] PIPE_DIV = 2'd2;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_B2 = 1'b1
    } beat_state_e;

    // Ready bit of the selected pipe; encoding 3 is illegal and never ready.
    function automatic logic pipe_ready(input logic [1:0] sel, input logic [2:0] rdy);
        logic r;
        case (sel)
            PIPE_ADD: r = rdy[0];
            PIPE_MUL: r = rdy[1];
            PIPE_DIV: r = rdy[2];
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

    // One-hot issue strobe for a pipe select; encoding 3 maps to no strobe.
    function automatic logic [2:0] pipe_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            PIPE_ADD: oh = 3'b001;
            PIPE_MUL: oh = 3'b010;
            PIPE_DIV: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fpu_inq_ptr.sv
// Input-queue pointer and occupancy tracker.
// Ports:
//   rclk, grst_l      clock, synchronous active-low reset
//   enq, deq          push / pop strobes for this cycle (caller guarantees
//                     enq is never raised on a full queue without deq, and
//                     deq is never raised on an empty queue)
//   wr_ptr, rd_ptr    SRAM write / read addresses, wrapping DEPTH-1 -> 0
//   cnt               occupancy, 0..DEPTH
//   full, empty       cnt==DEPTH, cnt==0
module fpu_inq_ptr
    import fpu_inq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = 4
) (
    input  logic             rclk,
    input  logic             grst_l,
    input  logic             enq,
    input  logic             deq,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   cnt,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge rclk) begin
        if (!grst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            if (enq && !deq)      cnt <= cnt + (PTR_W+1)'(1);
            else if (deq && !enq) cnt <= cnt - (PTR_W+1)'(1);
        end
    end

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

endmodule

// File: rtl/fpu_inq_ctl.sv
// FPU input-queue control.
// Collects one- or two-beat PCX requests, then either forwards the request
// straight to its pipe (queue empty and pipe ready), or writes it into the
// input-queue SRAM. The queue head issues when its pipe is ready; every issue
// (forward or dequeue) returns one PCX credit.
// Ports:
//   rclk, grst_l               clock, synchronous active-low reset
//   beat_vld, beat_1src        PCX beat strobe and single-source flag
//   in_pipe_sel                target pipe of the incoming request
//   head_pipe_sel              target pipe of the queue head
//   pipe_rdy                   per-pipe ready (bit0 add, bit1 mul, bit2 div)
//   fp_data_rdy                capture enable for the first operand beat
//   inq_fwrd(_inv)             forward select for the datapath
//   inq_bp(_inv)               bypass select (last-written entry at the head)
//   inq_we, inq_wr_ptr         SRAM write enable / address
//   inq_rd_ptr                 SRAM read address
//   iss_vld                    one-hot issue strobe
//   fpu_pcx_credit             credit-return pulse
//   inq_cnt, inq_empty         occupancy
//   inq_ovf                    sticky credit-violation flag
//
// Handshake: an issue to a pipe happens in exactly the cycle where a request
// is valid (forwarded or at the queue head) and that pipe's pipe_rdy bit is 1;
// iss_vld is the transfer strobe, there is no holding of strobes across
// cycles. Beats have no back-pressure: beat_vld is always accepted.
//
// The beat FSM state is the internal signal 'state' for external checkers.
module fpu_inq_ctl
    import fpu_inq_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = 4
) (
    input  logic             rclk,
    input  logic             grst_l,
    input  logic             beat_vld,
    input  logic             beat_1src,
    input  logic [1:0]       in_pipe_sel,
    input  logic [1:0]       head_pipe_sel,
    input  logic [2:0]       pipe_rdy,
    output logic             fp_data_rdy,
    output logic             inq_fwrd,
    output logic             inq_fwrd_inv,
    output logic             inq_bp,
    output logic             inq_bp_inv,
    output logic             inq_we,
    output logic [PTR_W-1:0] inq_wr_ptr,
    output logic [PTR_W-1:0] inq_rd_ptr,
    output logic [2:0]       iss_vld,
    output logic             fpu_pcx_credit,
    output logic [PTR_W:0]   inq_cnt,
    output logic             inq_empty,
    output logic             inq_ovf
);

    beat_state_e      state, state_nxt;
    logic             req_done;
    logic             fwd, deq, enq, ovf_hit;
    logic             full;
    logic             last_wr_vld;
    logic [PTR_W-1:0] last_wr_ptr;

    // ---------------- beat FSM ----------------
    always_ff @(posedge rclk) begin
        if (!grst_l) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req_done    = 1'b0;
        fp_data_rdy = 1'b0;
        case (state)
            IDLE: begin
                if (beat_vld && beat_1src) begin
                    req_done = 1'b1;
                end else if (beat_vld) begin
                    fp_data_rdy = 1'b1;
                    state_nxt   = WAIT_B2;
                end
            end
            WAIT_B2: begin
                if (beat_vld) begin
                    req_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A request completing under reset is dropped: no write, no credit.
        if (!grst_l) req_done = 1'b0;
    end

    // ---------------- source selection ----------------
    // Forward only from an empty queue, so ordering is preserved; fwd and
    // deq are therefore mutually exclusive and at most one pipe is strobed.
    assign fwd     = req_done && inq_empty && pipe_ready(in_pipe_sel, pipe_rdy);
    assign deq     = grst_l && !inq_empty && pipe_ready(head_pipe_sel, pipe_rdy);
    // A full queue accepts a new write only when the head leaves this cycle.
    assign ovf_hit = req_done && full && !deq;
    assign enq     = req_done && !fwd && !ovf_hit;

    assign inq_we       = enq;
    assign inq_fwrd     = fwd;
    assign inq_fwrd_inv = ~fwd;

    always_comb begin
        iss_vld = 3'b000;
        if (fwd)      iss_vld = pipe_onehot(in_pipe_sel);
        else if (deq) iss_vld = pipe_onehot(head_pipe_sel);
    end

    assign fpu_pcx_credit = fwd || deq;

    // ---------------- pointers / occupancy ----------------
    fpu_inq_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr (
        .rclk   (rclk),
        .grst_l (grst_l),
        .enq    (enq),
        .deq    (deq),
        .wr_ptr (inq_wr_ptr),
        .rd_ptr (inq_rd_ptr),
        .cnt    (inq_cnt),
        .full   (full),
        .empty  (inq_empty)
    );

    // ---------------- bypass / overflow ----------------
    // The SRAM does not write through, so an entry written last cycle that
    // is now at the head must be taken from the write-data bypass instead.
    always_ff @(posedge rclk) begin
        if (!grst_l) begin
            last_wr_vld <= 1'b0;
            last_wr_ptr <= '0;
            inq_ovf     <= 1'b0;
        end else begin
            last_wr_vld <= enq;
            last_wr_ptr <= inq_wr_ptr;
            if (ovf_hit) inq_ovf <= 1'b1;
        end
    end

    assign inq_bp     = last_wr_vld && (last_wr_ptr == inq_rd_ptr) && !inq_empty;
    assign inq_bp_inv = ~inq_bp;

endmodule

// File: tb/tb_fpu_inq_ctl.sv
// Directed bench for fpu_inq_ctl. Inputs change 1ns after a rising edge,
// combinational outputs are checked 1ns later, state is checked after the
// following edge.
module tb_fpu_inq_ctl;
    import fpu_inq_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             rclk = 1'b0;
    logic             grst_l;
    logic             beat_vld, beat_1src;
    logic [1:0]       in_pipe_sel, head_pipe_sel;
    logic [2:0]       pipe_rdy;
    logic             fp_data_rdy, inq_fwrd, inq_fwrd_inv, inq_bp, inq_bp_inv;
    logic             inq_we, fpu_pcx_credit, inq_empty, inq_ovf;
    logic [PTR_W-1:0] inq_wr_ptr, inq_rd_ptr;
    logic [2:0]       iss_vld;
    logic [PTR_W:0]   inq_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int credits;

    always #5 rclk = ~rclk;

    fpu_inq_ctl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .rclk           (rclk),
        .grst_l         (grst_l),
        .beat_vld       (beat_vld),
        .beat_1src      (beat_1src),
        .in_pipe_sel    (in_pipe_sel),
        .head_pipe_sel  (head_pipe_sel),
        .pipe_rdy       (pipe_rdy),
        .fp_data_rdy    (fp_data_rdy),
        .inq_fwrd       (inq_fwrd),
        .inq_fwrd_inv   (inq_fwrd_inv),
        .inq_bp         (inq_bp),
        .inq_bp_inv     (inq_bp_inv),
        .inq_we         (inq_we),
        .inq_wr_ptr     (inq_wr_ptr),
        .inq_rd_ptr     (inq_rd_ptr),
        .iss_vld        (iss_vld),
        .fpu_pcx_credit (fpu_pcx_credit),
        .inq_cnt        (inq_cnt),
        .inq_empty      (inq_empty),
        .inq_ovf        (inq_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic bv, input logic b1, input logic [1:0] ips,
                         input logic [1:0] hps, input logic [2:0] rdy);
        beat_vld      = bv;
        beat_1src     = b1;
        in_pipe_sel   = ips;
        head_pipe_sel = hps;
        pipe_rdy      = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset();
        grst_l = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 2'd0, 3'b000);
        tick();
        tick();
        grst_l = 1'b1;
    endtask

    initial begin
        do_reset();

        // ---- reset state ----
        chk("rst_cnt",      32'(inq_cnt), 0);
        chk("rst_empty",    32'(inq_empty), 1);
        chk("rst_fwrd_inv", 32'(inq_fwrd_inv), 1);
        chk("rst_bp_inv",   32'(inq_bp_inv), 1);
        chk("rst_ovf",      32'(inq_ovf), 0);
        chk("rst_wr_ptr",   32'(inq_wr_ptr), 0);
        chk("rst_rd_ptr",   32'(inq_rd_ptr), 0);

        // ---- forward: empty queue, single-source add, add ready ----
        drive(1'b1, 1'b1, PIPE_ADD, PIPE_ADD, 3'b001);
        chk("fwd_fwrd",   32'(inq_fwrd), 1);
        chk("fwd_iss",    32'(iss_vld), 32'b001);
        chk("fwd_credit", 32'(fpu_pcx_credit), 1);
        chk("fwd_we",     32'(inq_we), 0);
        tick();
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_ADD, 3'b000);
        chk("fwd_cnt", 32'(inq_cnt), 0);

        // ---- two-source mul, pipes stalled ----
        drive(1'b1, 1'b0, PIPE_MUL, PIPE_MUL, 3'b000);
        chk("b1_data_rdy", 32'(fp_data_rdy), 1);
        chk("b1_we",       32'(inq_we), 0);
        tick();
        drive(1'b1, 1'b1, PIPE_MUL, PIPE_MUL, 3'b000);  // beat_1src ignored here
        chk("b2_data_rdy", 32'(fp_data_rdy), 0);
        chk("b2_we",       32'(inq_we), 1);
        chk("b2_wr_ptr",   32'(inq_wr_ptr), 0);
        chk("b2_iss",      32'(iss_vld), 0);
        tick();
        drive(1'b0, 1'b0, PIPE_MUL, PIPE_MUL, 3'b000);
        chk("q1_cnt",    32'(inq_cnt), 1);
        chk("q1_bp",     32'(inq_bp), 1);
        chk("q1_bp_inv", 32'(inq_bp_inv), 0);
        chk("q1_fwrd",   32'(inq_fwrd), 0);
        chk("q1_iss0",   32'(iss_vld), 0);
        drive(1'b0, 1'b0, PIPE_MUL, PIPE_MUL, 3'b010);
        chk("q1_iss",    32'(iss_vld), 32'b010);
        chk("q1_credit", 32'(fpu_pcx_credit), 1);
        tick();
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_ADD, 3'b000);
        chk("q1_cnt_after", 32'(inq_cnt), 0);
        chk("q1_rd_ptr",    32'(inq_rd_ptr), 1);

        // ---- fill 16, overflow on 17th, drain 16 ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b1, PIPE_ADD, PIPE_ADD, 3'b000);
            chk("fill_we", 32'(inq_we), 1);
            chk("fill_wr_ptr", 32'(inq_wr_ptr), 32'(i));
            tick();
        end
        drive(1'b1, 1'b1, PIPE_ADD, PIPE_ADD, 3'b000);
        chk("full_cnt", 32'(inq_cnt), 16);
        chk("ovf_we",   32'(inq_we), 0);
        tick();
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_ADD, 3'b000);
        chk("ovf_flag",   32'(inq_ovf), 1);
        chk("ovf_cnt",    32'(inq_cnt), 16);
        chk("ovf_wr_ptr", 32'(inq_wr_ptr), 0);
        credits = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, PIPE_ADD, PIPE_ADD, 3'b001);
            if (fpu_pcx_credit) credits++;
            tick();
        end
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_ADD, 3'b000);
        chk("drain_credits", 32'(credits), 16);
        chk("drain_rd_ptr",  32'(inq_rd_ptr), 0);
        chk("drain_empty",   32'(inq_empty), 1);
        chk("drain_ovf_sticky", 32'(inq_ovf), 1);

        // ---- simultaneous enqueue / dequeue at cnt=3 ----
        do_reset();
        chk("rst2_ovf", 32'(inq_ovf), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, PIPE_ADD, PIPE_ADD, 3'b000);
            tick();
        end
        drive(1'b1, 1'b1, PIPE_ADD, PIPE_ADD, 3'b001);
        chk("ed_cnt_before", 32'(inq_cnt), 3);
        chk("ed_fwrd",   32'(inq_fwrd), 0);
        chk("ed_we",     32'(inq_we), 1);
        chk("ed_wr_ptr", 32'(inq_wr_ptr), 3);
        chk("ed_iss",    32'(iss_vld), 32'b001);
        chk("ed_credit", 32'(fpu_pcx_credit), 1);
        chk("ed_bp",     32'(inq_bp), 0);
        tick();
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_ADD, 3'b000);
        chk("ed_cnt",    32'(inq_cnt), 3);
        chk("ed_rd_adv", 32'(inq_rd_ptr), 1);
        chk("ed_wr_adv", 32'(inq_wr_ptr), 4);

        // ---- reset while in WAIT_B2 ----
        do_reset();
        drive(1'b1, 1'b0, PIPE_ADD, PIPE_ADD, 3'b000);
        chk("wr_b1_data_rdy", 32'(fp_data_rdy), 1);
        tick();
        grst_l = 1'b0;
        drive(1'b1, 1'b1, PIPE_ADD, PIPE_ADD, 3'b001);
        chk("rst_b2_we",     32'(inq_we), 0);
        chk("rst_b2_credit", 32'(fpu_pcx_credit), 0);
        tick();
        grst_l = 1'b1;
        drive(1'b1, 1'b0, PIPE_ADD, PIPE_ADD, 3'b000);
        chk("post_rst_data_rdy", 32'(fp_data_rdy), 1);
        chk("post_rst_we",       32'(inq_we), 0);
        chk("post_rst_cnt",      32'(inq_cnt), 0);
        tick();
        drive(1'b1, 1'b1, PIPE_DIV, PIPE_DIV, 3'b000);
        chk("post_rst_b2_we", 32'(inq_we), 1);
        tick();

        // ---- div head waits for its own ready bit ----
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_DIV, 3'b011);
        chk("div_cnt",     32'(inq_cnt), 1);
        chk("div_stall0",  32'(iss_vld), 0);
        chk("div_nocred0", 32'(fpu_pcx_credit), 0);
        tick();
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_DIV, 3'b011);
        chk("div_stall1",  32'(iss_vld), 0);
        tick();
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_DIV, 3'b111);
        chk("div_iss",    32'(iss_vld), 32'b100);
        chk("div_credit", 32'(fpu_pcx_credit), 1);
        tick();
        drive(1'b0, 1'b0, PIPE_ADD, PIPE_DIV, 3'b000);
        chk("div_empty", 32'(inq_empty), 1);

        // ---- illegal pipe select 3 never issues ----
        drive(1'b1, 1'b1, 2'd3, 2'd3, 3'b111);
        chk("sel3_fwrd", 32'(inq_fwrd), 0);
        chk("sel3_we",   32'(inq_we), 1);
        chk("sel3_iss",  32'(iss_vld), 0);
        tick();
        drive(1'b0, 1'b0, 2'd3, 2'd3, 3'b111);
        chk("sel3_head_iss", 32'(iss_vld), 0);
        chk("sel3_head_cnt", 32'(inq_cnt), 1);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
